// File: rtl/mips_defs.sv
// Shared writeback definitions: register-address width, the r0 constant and the
// writeback entry layout used for MDU results.
package mips_defs;
  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wreg;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// MDU result queue: circular buffer with per-entry valid bits, kill-by-register
// and two combinational "valid entry targets register q" match outputs.
module wb_fifo
  import mips_defs::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_enq,
  input  logic [REG_ADDR_W-1:0] i_enq_reg,
  input  logic [WIDTH-1:0]      i_enq_data,
  input  logic                  i_deq,
  input  logic                  i_kill,
  input  logic [REG_ADDR_W-1:0] i_kill_reg,
  input  logic [REG_ADDR_W-1:0] i_qa,
  input  logic [REG_ADDR_W-1:0] i_qb,
  output logic                  o_head_valid,
  output logic [REG_ADDR_W-1:0] o_head_reg,
  output logic [WIDTH-1:0]      o_head_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_match_a,
  output logic                  o_match_b
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0]      r_valid;
  logic [REG_ADDR_W-1:0] r_reg  [DEPTH];
  logic [WIDTH-1:0]      r_data [DEPTH];
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_reg[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_kill && (r_reg[AW'(i)] == i_kill_reg)) r_valid[AW'(i)] <= 1'b0;
      end
      // Slots leaving the queue lose their valid bit so matches see only live entries.
      if (i_deq) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + 1'b1;
      end
      if (i_enq) begin
        r_valid[r_tail] <= 1'b1;
        r_reg[r_tail]   <= i_enq_reg;
        r_data[r_tail]  <= i_enq_data;
        r_tail          <= r_tail + 1'b1;
      end
      case ({i_enq, i_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    o_match_a = 1'b0;
    o_match_b = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (r_valid[AW'(i)] && (r_reg[AW'(i)] == i_qa)) o_match_a = 1'b1;
      if (r_valid[AW'(i)] && (r_reg[AW'(i)] == i_qb)) o_match_b = 1'b1;
    end
  end

  assign o_head_valid = r_valid[r_head];
  assign o_head_reg   = r_reg[r_head];
  assign o_head_data  = r_data[r_head];
  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CW'(DEPTH));
endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback stage owning the register-file write port: pipeline results win,
// MDU results queue and drain on idle cycles, r0 writes are filtered out.
module wb_port_arbiter
  import mips_defs::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid,
  input  logic [REG_ADDR_W-1:0] pipe_wreg,
  input  logic [WIDTH-1:0]      pipe_wdata,
  input  logic                  mdu_valid,
  input  logic [REG_ADDR_W-1:0] mdu_wreg,
  input  logic [WIDTH-1:0]      mdu_wdata,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] q_a,
  input  logic [REG_ADDR_W-1:0] q_b,
  output logic                  pend_a,
  output logic                  pend_b,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]      rf_wdata
);
  logic                  w_pipe_eff;
  logic                  w_mdu_xfer;
  logic                  w_enq;
  logic                  w_deq;
  logic                  w_head_valid;
  logic [REG_ADDR_W-1:0] w_head_reg;
  logic [WIDTH-1:0]      w_head_data;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_match_a;
  logic                  w_match_b;

  assign w_pipe_eff = pipe_valid && (pipe_wreg != ZERO_REG);
  assign w_mdu_xfer = mdu_valid && mdu_ready;
  // A same-cycle pipe write to the same register supersedes the older MDU result.
  assign w_enq = w_mdu_xfer && (mdu_wreg != ZERO_REG) &&
                 !(w_pipe_eff && (mdu_wreg == pipe_wreg));
  assign w_deq = !w_pipe_eff && !w_empty;

  wb_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_enq       (w_enq),
    .i_enq_reg   (mdu_wreg),
    .i_enq_data  (mdu_wdata),
    .i_deq       (w_deq),
    .i_kill      (w_pipe_eff),
    .i_kill_reg  (pipe_wreg),
    .i_qa        (q_a),
    .i_qb        (q_b),
    .o_head_valid(w_head_valid),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_match_a   (w_match_a),
    .o_match_b   (w_match_b)
  );

  assign mdu_ready = !w_full;
  assign pend_a    = (q_a != ZERO_REG) && w_match_a;
  assign pend_b    = (q_b != ZERO_REG) && w_match_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (w_pipe_eff) begin
      rf_we    <= 1'b1;
      rf_waddr <= pipe_wreg;
      rf_wdata <= pipe_wdata;
    end else if (w_deq && w_head_valid) begin
      rf_we    <= 1'b1;
      rf_waddr <= w_head_reg;
      rf_wdata <= w_head_data;
    end else begin
      rf_we <= 1'b0;
    end
  end
endmodule
